lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 53 +++++
 rtl/lsu_ctrl.sv | 162 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Load/store unit bundle: pipeline request, memory port and response channel.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
//
// Modports: slave = the LSU itself, master = the pipeline/memory environment around it.
interface lsu_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] fw_data;
    logic                  fw_sel;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_byte_slct;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;
    logic [1:0]            resp_err_code;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, fw_data, fw_sel,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_byte_slct,
        input  mem_rdata, mem_ack,
        output resp_valid, resp_data, resp_err, resp_err_code,
        input  resp_ready
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, fw_data, fw_sel,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_byte_slct,
        output mem_rdata, mem_ack,
        input  resp_valid, resp_data, resp_err, resp_err_code,
        output resp_ready
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller with big-endian lane steering, alignment and timeout checks.
// Latency: accept N -> mem_req N+1 -> resp_valid N+2 at best; alignment/size errors respond at N+1.
// Backpressure: req_ready only in IDLE; the response is held stable until resp_valid&resp_ready.
//
// Ports: clk, rst (sync, active-low), bus (lsu_ctrl_if.slave: request, memory, response), busy.
module lsu_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    lsu_ctrl_if.slave   bus,
    output logic        busy
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFS = $clog2(NB);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            wait_q, wait_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            code_q, code_d;

    // Access size in bytes: 1, 2, 4, 8.
    function automatic logic [3:0] size_bytes(input logic [1:0] s);
        return 4'd1 << s;
    endfunction

    // Repeat the low access-size bytes of src across every lane.
    function automatic logic [DATA_WIDTH-1:0] replicate(input logic [DATA_WIDTH-1:0] src,
                                                        input logic [1:0] s);
        logic [DATA_WIDTH-1:0] r;
        int                    u;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            u = i & ((1 << s) - 1);
            r[8*i +: 8] = src[8*u +: 8];
        end
        return r;
    endfunction

    logic [3:0]            sb_in;
    logic                  illegal_in, misalign_in;
    logic [OFS-1:0]        k;
    logic [7:0]            load_shl, load_shr;
    logic [DATA_WIDTH-1:0] shifted, load_val;
    logic [NB-1:0]         slct_full;

    always_comb begin
        sb_in       = size_bytes(bus.req_size);
        illegal_in  = (bus.req_size == 2'b11) && (DATA_WIDTH == 32);
        misalign_in = (bus.req_addr[2:0] & 3'(sb_in - 4'd1)) != 3'd0;

        // Lane k sits at the MSB end; move it to the top, then shift the
        // access down so it ends up right-justified.
        k        = addr_q[OFS-1:0];
        load_shl = 8'({k, 3'b000});
        load_shr = 8'(DATA_WIDTH) - (8'(size_bytes(size_q)) << 3);
        shifted  = bus.mem_rdata << load_shl;
        if (signed_q) load_val = $signed(shifted) >>> load_shr;
        else          load_val = shifted >> load_shr;

        slct_full = ~({NB{1'b1}} >> size_bytes(size_q));
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wait_d   = wait_q;
        rdata_d  = rdata_q;
        code_d   = code_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    addr_d   = bus.req_addr;
                    wdata_d  = replicate(bus.fw_sel ? bus.fw_data : bus.req_wdata, bus.req_size);
                    rdata_d  = '0;
                    wait_d   = 8'd0;
                    if (illegal_in) begin
                        code_d  = 2'b11;
                        state_d = RESP;
                    end else if (misalign_in) begin
                        code_d  = 2'b01;
                        state_d = RESP;
                    end else begin
                        code_d  = 2'b00;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (bus.mem_ack) begin
                    rdata_d = we_q ? '0 : load_val;
                    code_d  = 2'b00;
                    state_d = RESP;
                end else if (wait_q == 8'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    code_d  = 2'b10;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_q   <= 8'd0;
            rdata_q  <= '0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wait_q   <= wait_d;
            rdata_q  <= rdata_d;
            code_q   <= code_d;
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.mem_req       = (state_q == ACCESS);
    assign bus.mem_we        = bus.mem_req & we_q;
    assign bus.mem_addr      = {addr_q[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
    assign bus.mem_wdata     = wdata_q;
    // Strobes only while requesting; the latched size alone would light lanes at reset.
    assign bus.mem_byte_slct = bus.mem_req ? (slct_full >> k) : '0;
    assign bus.resp_valid    = (state_q == RESP);
    assign bus.resp_data     = rdata_q;
    assign bus.resp_err      = (code_q != 2'b00);
    assign bus.resp_err_code = code_q;
    assign busy              = (state_q != IDLE);
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a 32-bit instance (TIMEOUT=4) and a 64-bit instance.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
// Every comparison goes through chk.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy32, busy64;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    lsu_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b32 ();
    lsu_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) b64 ();

    lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) u32 (
        .clk(clk), .rst(rst), .bus(b32.slave), .busy(busy32));
    lsu_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(16)) u64 (
        .clk(clk), .rst(rst), .bus(b64.slave), .busy(busy64));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send32(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, input logic fs, input logic [31:0] fd);
        b32.req_we = we; b32.req_size = sz; b32.req_signed = sg; b32.req_addr = a;
        b32.req_wdata = wd; b32.fw_sel = fs; b32.fw_data = fd; b32.req_valid = 1'b1;
        @(negedge clk);
        b32.req_valid = 1'b0;
    endtask

    task automatic ack32(input logic [31:0] rd);
        b32.mem_rdata = rd; b32.mem_ack = 1'b1;
        @(negedge clk);
        b32.mem_ack = 1'b0;
    endtask

    task automatic done32();
        b32.resp_ready = 1'b1;
        @(negedge clk);
        b32.resp_ready = 1'b0;
        chk("done_resp_valid", b32.resp_valid, 0);
        chk("done_req_ready", b32.req_ready, 1);
    endtask

    int cnt;

    initial begin
        b32.req_valid = 0; b32.req_we = 0; b32.req_size = 0; b32.req_signed = 0; b32.req_addr = 0;
        b32.req_wdata = 0; b32.fw_data = 0; b32.fw_sel = 0; b32.mem_rdata = 0; b32.mem_ack = 0;
        b32.resp_ready = 0;
        b64.req_valid = 0; b64.req_we = 0; b64.req_size = 0; b64.req_signed = 0; b64.req_addr = 0;
        b64.req_wdata = 0; b64.fw_data = 0; b64.fw_sel = 0; b64.mem_rdata = 0; b64.mem_ack = 0;
        b64.resp_ready = 0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_mem_req", b32.mem_req, 0);
        chk("rst_mem_we", b32.mem_we, 0);
        chk("rst_mem_addr", b32.mem_addr, 0);
        chk("rst_mem_wdata", b32.mem_wdata, 0);
        chk("rst_byte_slct", b32.mem_byte_slct, 0);
        chk("rst_resp_valid", b32.resp_valid, 0);
        chk("rst_resp_data", b32.resp_data, 0);
        chk("rst_resp_err", b32.resp_err, 0);
        chk("rst_err_code", b32.resp_err_code, 0);
        chk("rst_busy", busy32, 0);
        chk("rst_busy64", busy64, 0);
        chk("rst_slct64", b64.mem_byte_slct, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", b32.req_ready, 1);

        // lb signed, byte 1
        send32(0, 2'b00, 1, 32'h0000_1001, 0, 0, 0);
        chk("lb_mem_req", b32.mem_req, 1);
        chk("lb_busy", busy32, 1);
        chk("lb_req_ready", b32.req_ready, 0);
        chk("lb_slct", b32.mem_byte_slct, 4'b0100);
        chk("lb_addr", b32.mem_addr, 32'h0000_1000);
        chk("lb_we", b32.mem_we, 0);
        ack32(32'h12F4_5678);
        chk("lb_resp_valid", b32.resp_valid, 1);
        chk("lb_data", b32.resp_data, 32'hFFFF_FFF4);
        chk("lb_code", b32.resp_err_code, 0);
        chk("lb_mem_req_off", b32.mem_req, 0);
        done32();

        // lbu same address
        send32(0, 2'b00, 0, 32'h0000_1001, 0, 0, 0);
        ack32(32'h12F4_5678);
        chk("lbu_data", b32.resp_data, 32'h0000_00F4);
        done32();

        // sh with forwarded store data
        send32(1, 2'b01, 0, 32'h0000_2002, 32'h0000_ABCD, 1, 32'h0000_1234);
        chk("sh_wdata", b32.mem_wdata, 32'h1234_1234);
        chk("sh_slct", b32.mem_byte_slct, 4'b0011);
        chk("sh_we", b32.mem_we, 1);
        chk("sh_addr", b32.mem_addr, 32'h0000_2000);
        ack32(32'hFFFF_FFFF);
        chk("sh_resp_data", b32.resp_data, 0);
        chk("sh_err", b32.resp_err, 0);
        done32();

        // sb from register data, byte 3
        send32(1, 2'b00, 0, 32'h0000_3003, 32'h1111_11A5, 0, 32'h0000_0077);
        chk("sb_wdata", b32.mem_wdata, 32'hA5A5_A5A5);
        chk("sb_slct", b32.mem_byte_slct, 4'b0001);
        ack32(0);
        done32();

        // lh signed at offset 2, lw full word
        send32(0, 2'b01, 1, 32'h0000_4002, 0, 0, 0);
        ack32(32'h1234_8001);
        chk("lh_data", b32.resp_data, 32'hFFFF_8001);
        done32();
        send32(0, 2'b10, 0, 32'h0000_4004, 0, 0, 0);
        chk("lw_slct", b32.mem_byte_slct, 4'b1111);
        ack32(32'hDEAD_BEEF);
        chk("lw_data", b32.resp_data, 32'hDEAD_BEEF);
        done32();

        // Misaligned word, misaligned half, illegal dword on 32-bit
        send32(0, 2'b10, 0, 32'h0000_5002, 0, 0, 0);
        chk("mis_resp_valid", b32.resp_valid, 1);
        chk("mis_code", b32.resp_err_code, 2'b01);
        chk("mis_err", b32.resp_err, 1);
        chk("mis_mem_req", b32.mem_req, 0);
        done32();
        send32(0, 2'b01, 0, 32'h0000_5001, 0, 0, 0);
        chk("mish_code", b32.resp_err_code, 2'b01);
        done32();
        send32(0, 2'b11, 0, 32'h0000_5000, 0, 0, 0);
        chk("ill_code", b32.resp_err_code, 2'b11);
        chk("ill_mem_req", b32.mem_req, 0);
        done32();

        // Timeout: mem_req high for exactly 4 cycles
        send32(0, 2'b10, 0, 32'h0000_6000, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (b32.resp_valid) break;
            if (b32.mem_req) cnt++;
            @(negedge clk);
        end
        chk("to_req_cycles", cnt, 4);
        chk("to_code", b32.resp_err_code, 2'b10);
        chk("to_data", b32.resp_data, 0);
        chk("to_err", b32.resp_err, 1);
        done32();

        // Ack in the 4th (timeout) cycle wins
        send32(0, 2'b10, 0, 32'h0000_6000, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("ack4_mem_req", b32.mem_req, 1);
        ack32(32'h0BAD_F00D);
        chk("ack4_code", b32.resp_err_code, 2'b00);
        chk("ack4_data", b32.resp_data, 32'h0BAD_F00D);
        done32();

        // Ack in IDLE is ignored
        ack32(32'h5555_5555);
        chk("idle_ack_rv", b32.resp_valid, 0);
        chk("idle_ack_busy", busy32, 0);

        // Reset mid-access, then a late ack
        send32(0, 2'b10, 0, 32'h0000_7008, 0, 0, 0);
        chk("mid_mem_req", b32.mem_req, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_mem_req_off", b32.mem_req, 0);
        chk("mid_busy", busy32, 0);
        chk("mid_req_ready", b32.req_ready, 1);
        ack32(32'h1234_5678);
        chk("mid_late_rv", b32.resp_valid, 0);
        @(negedge clk);
        chk("mid_late_rv2", b32.resp_valid, 0);

        // 64-bit ld with response held off for 3 cycles
        b64.req_we = 0; b64.req_size = 2'b11; b64.req_signed = 0; b64.req_addr = 32'h0000_0108;
        b64.req_valid = 1;
        @(negedge clk);
        b64.req_valid = 0;
        chk("ld_addr", b64.mem_addr, 32'h0000_0108);
        chk("ld_slct", b64.mem_byte_slct, 8'hFF);
        b64.mem_rdata = 64'h8000_0000_0000_0001; b64.mem_ack = 1;
        @(negedge clk);
        b64.mem_ack = 0;
        b64.mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        for (int i = 0; i < 3; i++) begin
            chk("ld_hold_data", b64.resp_data, 64'h8000_0000_0000_0001);
            chk("ld_hold_rv", b64.resp_valid, 1);
            chk("ld_hold_ready", b64.req_ready, 0);
            @(negedge clk);
        end
        b64.resp_ready = 1;
        @(negedge clk);
        b64.resp_ready = 0;
        chk("ld_after_ready", b64.req_ready, 1);
        chk("ld_after_rv", b64.resp_valid, 0);

        // 64-bit lb at lane 5
        b64.req_size = 2'b00; b64.req_signed = 1; b64.req_addr = 32'h0000_010D; b64.req_valid = 1;
        @(negedge clk);
        b64.req_valid = 0;
        chk("lb64_slct", b64.mem_byte_slct, 8'b0000_0100);
        b64.mem_rdata = 64'h0011_2233_4455_6677; b64.mem_ack = 1;
        @(negedge clk);
        b64.mem_ack = 0;
        chk("lb64_data", b64.resp_data, 64'h0000_0000_0000_0055);
        b64.resp_ready = 1;
        @(negedge clk);
        b64.resp_ready = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
